bcd_display_scanner: RTL and testbench
======================================

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- REFRESH_DIV, 1000, clk cycles per digit slot; legal range is REFRESH_DIV >= 1.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-high.
- ones, in, 4, BCD units digit from the counter.
- tens, in, 4, BCD tens digit.
- hundred, in, 4, BCD hundreds digit.
- done, in, 1, counter wrap pulse (999->000).
- clr_ovf, in, 1, synchronous clear of the overflow flag.
- an, out, 3, digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds.
- seg, out, 7, segments {g,f,e,d,c,b,a}, active-low.
- dp, out, 1, decimal point, active-low.
- ovf, out, 1, sticky overflow flag.

Function
REQ-003 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick=1 in the cycle where the count equals REFRESH_DIV-1.
- With REFRESH_DIV=1, tick SHALL be 1 every cycle.
REQ-004 The digit index SHALL step DIG0->DIG1->DIG2->DIG0 on each tick edge and SHALL hold otherwise.
REQ-005 On the tick edge DIG2->DIG0 (frame boundary), shadow registers SHALL capture ones, tens and hundred together.
- The displayed value SHALL never mix digits from two different counts.
REQ-006 an, seg and dp SHALL be registers loaded on the tick edge with the values for the digit being entered; they SHALL hold between ticks.
REQ-007 On the frame-boundary edge, the DIG0 outputs SHALL be decoded from the live ones input, which is the value being captured that edge.
- DIG1 and DIG2 SHALL be decoded from the shadow registers.
REQ-008 an SHALL have exactly one bit low for the active digit; the other bits SHALL be high.
REQ-009 Segment decode SHALL be, as seg hex:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Codes 10-15 SHALL give 3F (only g lit).
REQ-010 ovf SHALL set on any cycle with done=1 and SHALL clear on a cycle with clr_ovf=1.
- If done and clr_ovf are both 1 in the same cycle, set SHALL win.
REQ-011 dp SHALL be 0 only while DIG0 is active and ovf=1; otherwise dp SHALL be 1.
- dp SHALL be registered with an and seg.
REQ-012 The block SHALL have no combinational path from any input to any output.

Reset
REQ-013 While reset=1 the block SHALL force, independent of clk:
- an=3'b111, seg=7'h7F, dp=1, ovf=0.
- prescaler=0, index=DIG2, shadow registers=0.
REQ-014 After reset releases, the first tick SHALL be a frame boundary (DIG2->DIG0), so the first digit displayed is the ones digit from fresh capture.
REQ-015 Reset asserted mid-frame or mid-slot SHALL abandon the frame; no partial state SHALL survive.

Configuration
REQ-016 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
- Defined: the hundreds digit SHALL blank when its value is 0; the tens digit SHALL blank when hundreds and tens are both 0; the ones digit SHALL never blank.
- A blanked slot SHALL drive an=3'b111, seg=7F and dp=1, and the slot timing SHALL be unchanged.
- Not defined: all three digits SHALL always be shown, including leading zeros.

Verification (REFRESH_DIV=4)
REQ-017 Reset, then hold ones=3, tens=2, hundred=1 -> an cycles 110,101,011 every 4 clks with seg 30,24,79.
REQ-018 Change ones from 3 to 4 mid-frame while DIG1 is active -> seg for DIG0 stays 30 until the next frame boundary, then shows 19.
REQ-019 Pulse done=1 for one cycle -> ovf=1 and dp=0 in every DIG0 slot; assert done and clr_ovf in the same cycle -> ovf stays 1; assert clr_ovf alone -> ovf=0.
REQ-020 Drive ones=4'hC -> seg=3F in the DIG0 slot.
REQ-021 Built with LEADING_ZERO_BLANK_EN and value 005 -> DIG2 and DIG1 slots show an=111, seg=7F; DIG0 shows an=110, seg=12. Built without it -> seg 40,40,12.
REQ-022 Assert reset mid-slot -> outputs go to reset values with no clk edge; after release, the first tick enters DIG0.

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// Bundle between a BCD counter, the display scanner and the 3-digit LED display.
// master: counter/display side; slave: the scanner itself.
interface bcd_display_scanner_if;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundred;
  logic       done;
  logic       clr_ovf;
  logic [2:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       ovf;

  modport master (
    output ones, tens, hundred, done, clr_ovf,
    input  an, seg, dp, ovf
  );

  modport slave (
    input  ones, tens, hundred, done, clr_ovf,
    output an, seg, dp, ovf
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 3-digit 7-segment scanner with frame-coherent capture and sticky overflow.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input logic                   clk,
  input logic                   reset,
  bcd_display_scanner_if.slave  bus
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG1 = 2'd1;
  localparam logic [1:0] DIG2 = 2'd2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_sh_tens;
  logic [3:0]    r_sh_hund;
  logic [2:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_ovf;

  logic          w_tick;
  logic          w_frame;
  logic          w_blank;
  logic [1:0]    w_nxt_idx;
  logic [2:0]    w_nxt_an;
  logic [6:0]    w_nxt_seg;
  logic          w_nxt_dp;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h40;
      4'd1:    f_seg = 7'h79;
      4'd2:    f_seg = 7'h24;
      4'd3:    f_seg = 7'h30;
      4'd4:    f_seg = 7'h19;
      4'd5:    f_seg = 7'h12;
      4'd6:    f_seg = 7'h02;
      4'd7:    f_seg = 7'h78;
      4'd8:    f_seg = 7'h00;
      4'd9:    f_seg = 7'h10;
      default: f_seg = 7'h3F;
    endcase
  endfunction

  assign w_tick  = (r_presc == LAST);
  assign w_frame = (r_idx == DIG2);

  // Entering DIG0 decodes the live ones input, which is what the shadows capture on that same edge.
  always_comb begin
    w_blank   = 1'b0;
    w_nxt_idx = DIG0;
    w_nxt_an  = 3'b110;
    w_nxt_seg = f_seg(bus.ones);
    w_nxt_dp  = ~r_ovf;
    case (r_idx)
      DIG0: begin
        w_nxt_idx = DIG1;
        w_nxt_an  = 3'b101;
        w_nxt_seg = f_seg(r_sh_tens);
        w_nxt_dp  = 1'b1;
        w_blank   = LZB && (r_sh_hund == 4'd0) && (r_sh_tens == 4'd0);
      end
      DIG1: begin
        w_nxt_idx = DIG2;
        w_nxt_an  = 3'b011;
        w_nxt_seg = f_seg(r_sh_hund);
        w_nxt_dp  = 1'b1;
        w_blank   = LZB && (r_sh_hund == 4'd0);
      end
      default: ;
    endcase
    if (w_blank) begin
      w_nxt_an  = '1;
      w_nxt_seg = '1;
      w_nxt_dp  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_idx     <= DIG2;
      r_sh_tens <= '0;
      r_sh_hund <= '0;
      r_an      <= '1;
      r_seg     <= '1;
      r_dp      <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= w_nxt_idx;
        r_an  <= w_nxt_an;
        r_seg <= w_nxt_seg;
        r_dp  <= w_nxt_dp;
        if (w_frame) begin
          r_sh_tens <= bus.tens;
          r_sh_hund <= bus.hundred;
        end
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (bus.done) begin
      r_ovf <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;
  assign bus.ovf = r_ovf;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (REFRESH_DIV=4) against a slot/frame-level model.
module tb_bcd_display_scanner;
  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic reset;
  bcd_display_scanner_if bus ();

  bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_t [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  int         n_cmp = 0;
  int         n_err = 0;

  // Model: cycles since reset, ticks since reset, captured digits, expected outputs.
  int         m_n;
  int         m_ticks;
  logic [3:0] m_cap [0:2];
  logic       m_ovf;
  logic [2:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;

  task automatic model_reset();
    m_n = 0; m_ticks = 0;
    m_cap[0] = 4'd0; m_cap[1] = 4'd0; m_cap[2] = 4'd0;
    m_ovf = 1'b0; m_an = 3'b111; m_seg = 7'h7F; m_dp = 1'b1;
  endtask

  function automatic int cur_digit();
    return (m_ticks == 0) ? -1 : (m_ticks - 1) % 3;
  endfunction

  task automatic model_edge();
    int   d;
    logic blank;
    logic ovf_prev;
    if (reset) begin
      model_reset();
      return;
    end
    ovf_prev = m_ovf;
    if (m_n % int'(DIV) == int'(DIV) - 1) begin
      m_ticks++;
      d = (m_ticks - 1) % 3;
      if (d == 0) begin
        m_cap[0] = bus.ones; m_cap[1] = bus.tens; m_cap[2] = bus.hundred;
      end
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (d == 2 && m_cap[2] == 4'd0) blank = 1'b1;
      if (d == 1 && m_cap[2] == 4'd0 && m_cap[1] == 4'd0) blank = 1'b1;
`endif
      if (blank) begin
        m_an = 3'b111; m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
        m_an  = ~(3'b001 << d);
        m_seg = seg_t[m_cap[d]];
        m_dp  = !(d == 0 && ovf_prev);
      end
    end
    if (bus.done) m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
    m_n++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".an"},  {5'd0, bus.an},  {5'd0, m_an});
    chk({tag, ".seg"}, {1'b0, bus.seg}, {1'b0, m_seg});
    chk({tag, ".dp"},  {7'd0, bus.dp},  {7'd0, m_dp});
    chk({tag, ".ovf"}, {7'd0, bus.ovf}, {7'd0, m_ovf});
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_val(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bus.hundred = h; bus.tens = t; bus.ones = o;
  endtask

  initial begin
    logic found;
    reset = 1'b1;
    set_val(4'd0, 4'd0, 4'd0);
    bus.done = 1'b0; bus.clr_ovf = 1'b0;
    model_reset();
    #2;
    check_all("reset");

    // Steady 321 scan
    @(negedge clk);
    set_val(4'd1, 4'd2, 4'd3);
    reset = 1'b0;
    repeat (24) cyc("scan321");

    // Change ones while DIG1 is showing: DIG0 keeps old capture until next frame
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (cur_digit() == 1) found = 1'b1;
      else cyc("seek_dig1");
    end
    chk("seek_dig1_bound", {7'd0, found}, 8'd1);
    bus.ones = 4'd4;
    repeat (15) cyc("midframe");

    // Overflow set, set-vs-clear priority, clear
    bus.done = 1'b1; cyc("done");
    bus.done = 1'b0; repeat (15) cyc("ovf_dp");
    bus.done = 1'b1; bus.clr_ovf = 1'b1; cyc("done_clr");
    bus.done = 1'b0; bus.clr_ovf = 1'b0; repeat (6) cyc("ovf_hold");
    bus.clr_ovf = 1'b1; cyc("clr");
    bus.clr_ovf = 1'b0; repeat (12) cyc("ovf_clear");

    // Invalid BCD code
    bus.ones = 4'hC;
    repeat (15) cyc("bad_code");

    // Leading zeros
    set_val(4'd0, 4'd0, 4'd5);
    repeat (15) cyc("val005");
    set_val(4'd0, 4'd7, 4'd0);
    repeat (15) cyc("val070");

    // Asynchronous reset mid-slot
    bus.done = 1'b1; cyc("pre_rst");
    bus.done = 1'b0; repeat (4) cyc("pre_rst");
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    repeat (2) cyc("in_rst");
    reset = 1'b0;
    repeat (12) cyc("post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        set_val(4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0)
        set_val(4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
      bus.done    = ($urandom_range(0, 29) == 0);
      bus.clr_ovf = ($urandom_range(0, 19) == 0);
      if (i == 200) begin
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("rand_rst");
        cyc("rand_in_rst");
        reset = 1'b0;
      end
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
